vga_output_stage: RTL
=====================

Name: vga_output_stage

Overview:
Parametrised successor to the current VGA colour output register; sits between the drawer and the board VGA pins. Aligns hsync, vsync and display_enable with the drawer's pipelined colour data through a configurable delay line. Adds a test-pattern/blank mode select and a frame-paced brightness fade engine (fade-out/fade-in) for level transitions. Blanks all colour outputs outside the active area.

Parameters:
COLOR_BITS, 4, bits per colour channel
PIPE_DEPTH, 2, drawer colour latency in cycles (>=0); delay applied to sync/enable
BRIGHT_BITS, 4, fade resolution; LEVEL_MAX = 2**BRIGHT_BITS
FRAMES_PER_STEP, 2, frame starts per fade level step (>=1)
BAR_WIDTH, 80, pixels per colour bar in test pattern
SYNC_ACTIVE_LOW, 1, polarity of hsync/vsync at input and output

Ports:
vga_clock  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
red_in/green_in/blue_in  in  COLOR_BITS each  drawer colour, valid PIPE_DEPTH cycles after matching sync/enable
display_enable  in  1  active-area flag, timing-aligned with hsync_in/vsync_in
hsync_in, vsync_in  in  1  raw sync from timing generator
mode  in  2  0 normal, 1 colour bars, 2 solid black, 3 solid white
fade_out_req, fade_in_req  in  1  single-cycle fade requests
vga_red/vga_green/vga_blue  out  COLOR_BITS each  pin colour
vga_hsync, vga_vsync  out  1  pin sync
fade_busy  out  1  high in FADE_OUT/FADE_IN
screen_dark  out  1  high when state is DARK

Behaviour:
- Reset (async, active-low): colours 0; syncs inactive (1 if SYNC_ACTIVE_LOW); state BRIGHT; level = LEVEL_MAX; frame-step counter 0; bar pixel counter 0; fade_busy=0, screen_dark=0. Reset mid-fade returns immediately to BRIGHT.
- Alignment: {display_enable, hsync_in, vsync_in} delayed PIPE_DEPTH cycles (de_d, hs_d, vs_d); PIPE_DEPTH=0 is a pass-through. All outputs registered once more: sync-in to sync-out latency PIPE_DEPTH+1; colour-in to colour-out latency 1.
- Bar counter: increments on each cycle de_d=1, clears when de_d=0. Bar index = counter/BAR_WIDTH, saturating at 7. Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black (all-ones or zero per channel).
- Source colour by mode: input colour, bar colour, all zeros, all ones.
- Scaling: out = (src * level) >> BRIGHT_BITS, computed at COLOR_BITS+BRIGHT_BITS+1 width; level=LEVEL_MAX reproduces src exactly, level 0 gives 0.
- Blank: de_d=0 forces colour outputs to 0 regardless of mode or level.
- Frame start: cycle when vs_d transitions inactive->active.
- FSM states BRIGHT, FADE_OUT, DARK, FADE_IN:
  BRIGHT: fade_out_req -> FADE_OUT.
  FADE_OUT: every FRAMES_PER_STEP frame starts, level decrements by 1; on reaching 0 -> DARK. fade_in_req -> FADE_IN keeping the current level.
  DARK: level 0; fade_in_req -> FADE_IN.
  FADE_IN: increments level at the same cadence; on reaching LEVEL_MAX -> BRIGHT. fade_out_req -> FADE_OUT keeping the current level.
- Requests not listed for a state are ignored. Simultaneous requests: fade_out_req wins. The step counter clears on every state change.
- Level update and frame start in the same cycle: the new level applies from the next cycle. Mid-frame level changes cannot occur, because steps happen only at frame start.

Decomposition:
- Package vga_pkg: mode_t enum (MODE_NORMAL, MODE_BARS, MODE_BLACK, MODE_WHITE), fade_state_t enum, 8-entry bar colour constant table (3-bit RGB masks).
- Sub-module vga_delay_line: parametrised WIDTH/DEPTH shift register with async active-low reset value input; used for the {de, hs, vs} bundle.

Test Plan:
- PIPE_DEPTH=2, hsync_in falls at cycle 10 -> vga_hsync falls at cycle 13; red_in=4'hA at cycle 12 with de_d=1 -> vga_red=4'hA at cycle 13.
- mode=1, full 640-pixel line -> vga outputs F/F/F for pixels 0-79, F/F/0 for 80-159, …, 0/0/0 for 560-639; 0 during blanking.
- fade_out_req, FRAMES_PER_STEP=2, BRIGHT_BITS=4, red_in=4'hF -> level steps 16→0 over 32 frame starts; red reads F, then E, …; screen_dark rises after the 32nd frame start.
- In FADE_OUT at level 9, pulse fade_in_req -> FADE_IN from level 9; BRIGHT reached after 14 more frame starts; fade_busy falls at that point.
- fade_out_req and fade_in_req in the same cycle while in BRIGHT -> state FADE_OUT.
- Assert reset at level 5 in FADE_IN -> same-cycle asynchronous clear: colours 0, syncs 1, level 16, fade_busy 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output stage: pixel source modes,
// fade engine states and the colour-bar RGB mask table.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_BLACK  = 2'd2,
    MODE_WHITE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    BRIGHT   = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam int NUM_BARS = 8;

  // {red, green, blue} masks, left to right across the screen
  localparam logic [2:0] BAR_RGB [NUM_BARS] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register that delays a small bundle by DEPTH cycles;
// DEPTH=0 collapses to a wire.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             vga_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] reset_value,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{vga_clock, reset, reset_value};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= reset_value;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_output_stage.sv
// Final pixel stage before the VGA pins: aligns sync with pipelined colour,
// selects test patterns, applies a frame-paced brightness fade and blanks.
module vga_output_stage
  import vga_pkg::*;
#(
  parameter int COLOR_BITS      = 4,
  parameter int PIPE_DEPTH      = 2,
  parameter int BRIGHT_BITS     = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int BAR_WIDTH       = 80,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] red_in,
  input  logic [COLOR_BITS-1:0] green_in,
  input  logic [COLOR_BITS-1:0] blue_in,
  input  logic                  display_enable,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [1:0]            mode,
  input  logic                  fade_out_req,
  input  logic                  fade_in_req,
  output logic [COLOR_BITS-1:0] vga_red,
  output logic [COLOR_BITS-1:0] vga_green,
  output logic [COLOR_BITS-1:0] vga_blue,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  fade_busy,
  output logic                  screen_dark
);

  localparam int LEVEL_MAX = 2 ** BRIGHT_BITS;
  localparam int LEVEL_W   = BRIGHT_BITS + 1;
  localparam int PROD_W    = COLOR_BITS + BRIGHT_BITS + 1;
  localparam int STEP_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int BAR_SPAN  = NUM_BARS * BAR_WIDTH;
  localparam int CNT_W     = $clog2(BAR_SPAN + 1);

  localparam logic               SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

  logic              de_d, hs_d, vs_d;
  logic              vs_prev;
  logic              frame_start;
  logic [CNT_W-1:0]  bar_cnt;
  logic [CNT_W-1:0]  bar_quot;
  logic [2:0]        bar_idx;
  logic [2:0]        bar_mask;
  logic [COLOR_BITS-1:0] src_red, src_green, src_blue;

  fade_state_t        state, state_next;
  logic [LEVEL_W-1:0] level, level_next;
  logic [STEP_W-1:0]  step_cnt, step_next;

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DEPTH)
  ) u_sync_delay (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .reset_value ({1'b0, SYNC_IDLE, SYNC_IDLE}),
    .din         ({display_enable, hsync_in, vsync_in}),
    .dout        ({de_d, hs_d, vs_d})
  );

  // A frame begins on the delayed vsync's idle-to-active edge
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) vs_prev <= SYNC_IDLE;
    else        vs_prev <= vs_d;
  end

  assign frame_start = (vs_prev == SYNC_IDLE) && (vs_d != SYNC_IDLE);

  // Pixel position within the active line; stops once past the last bar
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset)                          bar_cnt <= '0;
    else if (!de_d)                      bar_cnt <= '0;
    else if (bar_cnt != CNT_W'(BAR_SPAN)) bar_cnt <= bar_cnt + CNT_W'(1);
  end

  assign bar_quot = bar_cnt / CNT_W'(BAR_WIDTH);
  assign bar_idx  = (bar_quot > CNT_W'(NUM_BARS - 1)) ? 3'd7 : bar_quot[2:0];
  assign bar_mask = BAR_RGB[bar_idx];

  always_comb begin
    src_red   = red_in;
    src_green = green_in;
    src_blue  = blue_in;
    case (mode_t'(mode))
      MODE_BARS: begin
        src_red   = {COLOR_BITS{bar_mask[2]}};
        src_green = {COLOR_BITS{bar_mask[1]}};
        src_blue  = {COLOR_BITS{bar_mask[0]}};
      end
      MODE_BLACK: begin
        src_red   = '0;
        src_green = '0;
        src_blue  = '0;
      end
      MODE_WHITE: begin
        src_red   = '1;
        src_green = '1;
        src_blue  = '1;
      end
      default: ;
    endcase
  end

  // Full level (LEVEL_MAX) passes the colour through unchanged
  function automatic logic [COLOR_BITS-1:0] scale(input logic [COLOR_BITS-1:0] c,
                                                  input logic [LEVEL_W-1:0] l);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(l);
    return COLOR_BITS'(p >> BRIGHT_BITS);
  endfunction

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= SYNC_IDLE;
      vga_vsync <= SYNC_IDLE;
    end else begin
      vga_red   <= de_d ? scale(src_red,   level) : '0;
      vga_green <= de_d ? scale(src_green, level) : '0;
      vga_blue  <= de_d ? scale(src_blue,  level) : '0;
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state    <= BRIGHT;
      level    <= LVL_MAX;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      level    <= level_next;
      step_cnt <= step_next;
    end
  end

  // A fade_out_req always masks a coincident fade_in_req
  always_comb begin
    state_next = state;
    level_next = level;
    step_next  = step_cnt;
    case (state)
      BRIGHT: begin
        if (fade_out_req) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          state_next = FADE_IN;
        end else if (level == '0) begin
          state_next = DARK;
        end else if (frame_start) begin
          if (step_cnt == STEP_LAST) begin
            step_next  = '0;
            level_next = level - LEVEL_W'(1);
            if (level == LEVEL_W'(1)) state_next = DARK;
          end else begin
            step_next = step_cnt + STEP_W'(1);
          end
        end
      end
      DARK: begin
        level_next = '0;
        if (fade_in_req && !fade_out_req) state_next = FADE_IN;
      end
      FADE_IN: begin
        if (fade_out_req) begin
          state_next = FADE_OUT;
        end else if (level == LVL_MAX) begin
          state_next = BRIGHT;
        end else if (frame_start) begin
          if (step_cnt == STEP_LAST) begin
            step_next  = '0;
            level_next = level + LEVEL_W'(1);
            if (level == LVL_MAX - LEVEL_W'(1)) state_next = BRIGHT;
          end else begin
            step_next = step_cnt + STEP_W'(1);
          end
        end
      end
      default: state_next = BRIGHT;
    endcase
    if (state_next != state) step_next = '0;
  end

  always_comb begin
    fade_busy   = (state == FADE_OUT) || (state == FADE_IN);
    screen_dark = (state == DARK);
  end

endmodule
